branch_predict_unit: RTL
========================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have parameter ENTRY_NUM, default 64, meaning the number of table entries (power of 2, range 4..1024).
REQ-002 The block SHALL have parameter CNT_W, default 2, meaning the saturating counter width (range 1..4).
REQ-003 The block SHALL have parameter TGT_W, default 30, meaning the stored target width; the target is PC[31:2].
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port lookup_en, input, 1: a fetch-stage lookup request this cycle.
REQ-007 The block SHALL have port pc_F, input, 32: the fetch PC to look up.
REQ-008 The block SHALL have port pred_valid, output, 1: prediction outputs are valid this cycle.
REQ-009 The block SHALL have port pred_hit, output, 1: tag match on a valid entry.
REQ-010 The block SHALL have port pred_taken, output, 1: predicted taken.
REQ-011 The block SHALL have port pred_target, output, 32: predicted target {target, 2'b00}.
REQ-012 The block SHALL have port upd_en, input, 1: a resolved-branch update from execute.
REQ-013 The block SHALL have port upd_pc, input, 32: PC of the resolved branch.
REQ-014 The block SHALL have port upd_br_type, input, 4: branch type code (0000..0111 are branches; 1000 is a non-branch).
REQ-015 The block SHALL have port upd_taken, input, 1: actual outcome of the resolved branch.
REQ-016 The block SHALL have port upd_target, input, 32: actual taken target.
REQ-017 The block SHALL have port upd_mispred, input, 1: execute detected a misprediction.
REQ-018 The block SHALL have port tbl_clr, input, 1: synchronous invalidate-all.
REQ-019 The block SHALL have ports stat_lookup and stat_mispred, outputs, 32 each: statistics counters.

Function
REQ-020 The block SHALL compute IDX = log2(ENTRY_NUM); index = pc[IDX+1:2]; tag = pc[31:IDX+2].
REQ-021 Each entry SHALL hold a valid bit, a tag, a TGT_W target and a CNT_W counter.
REQ-022 Lookup latency SHALL be 1 cycle: pred_* are registered from the cycle in which lookup_en=1, and pred_valid=0 in the following cycle when lookup_en=0.
REQ-023 pred_hit SHALL be 1 when entry.valid=1 and the entry tag equals the tag of pc_F; pred_taken SHALL equal pred_hit & counter MSB; pred_target SHALL be 0 when there is no hit.
REQ-024 An update SHALL be written only when upd_en=1 and upd_br_type is less than 4'b1000; other codes SHALL be ignored.
REQ-025 On an update that hits, the counter SHALL increment when taken and decrement when not taken, saturating at all-ones and 0; the target SHALL be overwritten when taken.
REQ-026 On an update that misses, the entry SHALL be allocated (replacing any previous occupant): valid=1, new tag, target=upd_target[31:2]; counter = 10..0 (weak taken) if taken, else 01..1 (weak not-taken).
REQ-027 When a lookup and an update target the same index in the same cycle, the lookup SHALL return the post-update entry (write-first bypass).
REQ-028 When tbl_clr=1, all valid bits SHALL clear at the next edge; tbl_clr SHALL win over a simultaneous update, and a lookup in that cycle SHALL return pred_hit=0.
REQ-029 Counters and targets SHALL not be cleared by tbl_clr; only the valid bits SHALL clear.

Reset
REQ-030 While rst=1, all valid bits SHALL be 0, all counters SHALL be 01..1, and pred_valid, pred_hit, pred_taken, pred_target, stat_lookup and stat_mispred SHALL all be 0.
REQ-031 A reset asserted mid-operation SHALL take effect immediately without waiting for a clock edge; any update in flight SHALL be discarded.

Configuration
REQ-032 With macro BPU_STAT_EN defined, stat_lookup SHALL increment on each lookup_en=1 cycle.
REQ-033 With BPU_STAT_EN defined, stat_mispred SHALL increment on each upd_en & upd_mispred cycle; both counters SHALL wrap at 2^32 and be cleared only by rst.
REQ-034 Without BPU_STAT_EN, both stat outputs SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-035 Reset, then lookup 0xBFC00000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
REQ-036 Update pc=0xBFC00010, type 0000, taken, target 0x80001000, then lookup the same pc -> pred_hit=1, pred_taken=1, pred_target=0x80001000.
REQ-037 With CNT_W=2, apply 4 taken updates then 2 not-taken updates to one pc -> counter sequence 10,11,11,11,10,01, and a final lookup -> pred_taken=0.
REQ-038 Update and lookup the same index in the same cycle, ENTRY_NUM=64, pcs 0x100 and 0x200 (aliasing) -> lookup of 0x100 returns the new tag; a later lookup of 0x200 -> pred_hit=0.
REQ-039 Assert tbl_clr together with an update to 0x40 -> a later lookup of 0x40 -> pred_hit=0; an update with type 1000 -> no change to the table.
REQ-040 With BPU_STAT_EN defined, 10 lookups and 3 mispredict updates -> stat_lookup=10, stat_mispred=3; without the macro, both stay 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The fetch stage looks up a PC and gets a registered prediction
// one cycle later. The execute stage writes back resolved branches.
//
// Optional build macro: BPU_STAT_EN
//   defined   -> stat_lookup / stat_mispred are live 32-bit wrapping counters
//   undefined -> both stat outputs are tied to 0 and no counter flops exist
//
// Parameters
//   ENTRY_NUM : number of entries (power of 2, 4..1024)
//   CNT_W     : direction counter width (1..4)
//   TGT_W     : stored target width (target is PC[TGT_W+1:2])
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   lookup_en, pc_F      : fetch lookup request and PC
//   pred_valid           : one-cycle pulse, high in the cycle after lookup_en=1
//   pred_hit/taken/target: prediction for that lookup (target 0 on a miss)
//   upd_en, upd_pc       : resolved-branch update and its PC
//   upd_br_type          : 0000..0111 branch types, 1000 non-branch (ignored)
//   upd_taken/target     : actual outcome and taken target
//   upd_mispred          : execute flagged a misprediction (statistics only)
//   tbl_clr              : invalidate all entries at the next edge
//   stat_lookup/mispred  : statistics counters
//
// Handshake: there is no back-pressure. A lookup presented with lookup_en=1
// is always accepted, and its result appears with pred_valid=1 exactly one
// cycle later. An update presented with upd_en=1 is always accepted in that
// cycle.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int ENTRY_NUM = 64,
    parameter int CNT_W     = 2,
    parameter int TGT_W     = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_en,
    input  logic [31:0] pc_F,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [3:0]  upd_br_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred,
    input  logic        tbl_clr,
    output logic [31:0] stat_lookup,
    output logic [31:0] stat_mispred
);

    localparam int IDX   = $clog2(ENTRY_NUM);
    localparam int TAG_W = 30 - IDX;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Weak taken is 10..0, weak not-taken is 01..1 (one below weak taken).
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    // Table storage
    logic [ENTRY_NUM-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag [ENTRY_NUM];
    logic [TGT_W-1:0]     r_tgt [ENTRY_NUM];
    logic [CNT_W-1:0]     r_cnt [ENTRY_NUM];

    // Registered prediction
    logic        r_pred_valid;
    logic        r_pred_hit;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;

    // Update path
    logic [IDX-1:0]   w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_we;
    logic             w_upd_hit;
    logic [CNT_W-1:0] w_old_cnt;
    logic [TGT_W-1:0] w_old_tgt;
    logic [TGT_W-1:0] w_in_tgt;
    logic [CNT_W-1:0] w_new_cnt;
    logic [TGT_W-1:0] w_new_tgt;

    // Lookup path
    logic [IDX-1:0]   w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_byp;
    logic             w_ent_valid;
    logic [TAG_W-1:0] w_ent_tag;
    logic [TGT_W-1:0] w_ent_tgt;
    logic [CNT_W-1:0] w_ent_cnt;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [31:0]      w_lk_target;

    assign w_upd_idx = upd_pc[IDX+1:2];
    assign w_upd_tag = upd_pc[31:IDX+2];
    assign w_lk_idx  = pc_F[IDX+1:2];
    assign w_lk_tag  = pc_F[31:IDX+2];
    assign w_in_tgt  = upd_target[TGT_W+1:2];

    // Non-branch codes are dropped, and an invalidate-all in the same cycle
    // wins over the write.
    assign w_upd_we  = upd_en && (upd_br_type < 4'b1000) && !tbl_clr;
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_old_cnt = r_cnt[w_upd_idx];
    assign w_old_tgt = r_tgt[w_upd_idx];

    // Next counter / target for the entry being updated
    always_comb begin
        w_new_cnt = w_old_cnt;
        w_new_tgt = w_old_tgt;
        if (w_upd_hit) begin
            if (upd_taken) begin
                w_new_tgt = w_in_tgt;
                if (w_old_cnt != CNT_MAX) w_new_cnt = w_old_cnt + 1'b1;
            end else begin
                if (w_old_cnt != '0) w_new_cnt = w_old_cnt - 1'b1;
            end
        end else begin
            // Allocation replaces whatever was there; target is always loaded.
            w_new_tgt = w_in_tgt;
            w_new_cnt = upd_taken ? CNT_WT : CNT_WNT;
        end
    end

    // Valid bits and counters reset; tags and targets need no reset because
    // nothing reads them while the valid bit is clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) r_cnt[i] <= CNT_WNT;
        end else begin
            if (tbl_clr) begin
                r_valid <= '0;
            end else if (w_upd_we) begin
                r_valid[w_upd_idx] <= 1'b1;
            end
            if (w_upd_we) r_cnt[w_upd_idx] <= w_new_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_upd_we) begin
            r_tag[w_upd_idx] <= w_upd_tag;
            r_tgt[w_upd_idx] <= w_new_tgt;
        end
    end

    // Write-first bypass: a same-index update in this cycle is what the
    // lookup sees.
    assign w_lk_byp = w_upd_we && (w_upd_idx == w_lk_idx);

    always_comb begin
        w_ent_valid = r_valid[w_lk_idx];
        w_ent_tag   = r_tag[w_lk_idx];
        w_ent_tgt   = r_tgt[w_lk_idx];
        w_ent_cnt   = r_cnt[w_lk_idx];
        if (w_lk_byp) begin
            w_ent_valid = 1'b1;
            w_ent_tag   = w_upd_tag;
            w_ent_tgt   = w_new_tgt;
            w_ent_cnt   = w_new_cnt;
        end
    end

    always_comb begin
        w_lk_hit    = !tbl_clr && w_ent_valid && (w_ent_tag == w_lk_tag);
        w_lk_taken  = w_lk_hit && w_ent_cnt[CNT_W-1];
        w_lk_target = '0;
        if (w_lk_hit) w_lk_target[TGT_W+1:2] = w_ent_tgt;
    end

    // Prediction register; outputs other than pred_valid are zeroed in
    // cycles without a lookup so they never show stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid  <= 1'b0;
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_pred_valid  <= lookup_en;
            r_pred_hit    <= lookup_en && w_lk_hit;
            r_pred_taken  <= lookup_en && w_lk_taken;
            r_pred_target <= lookup_en ? w_lk_target : 32'd0;
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_hit    = r_pred_hit;
    assign pred_taken  = r_pred_taken;
    assign pred_target = r_pred_target;

`ifdef BPU_STAT_EN
    logic [31:0] r_stat_lookup;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_lookup  <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (lookup_en)              r_stat_lookup  <= r_stat_lookup + 32'd1;
            if (upd_en && upd_mispred)  r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_lookup  = r_stat_lookup;
    assign stat_mispred = r_stat_mispred;

    logic w_unused;
    assign w_unused = ^{pc_F[1:0], upd_pc[1:0], upd_target[1:0]};
`else
    assign stat_lookup  = '0;
    assign stat_mispred = '0;

    logic w_unused;
    assign w_unused = ^{pc_F[1:0], upd_pc[1:0], upd_target[1:0], upd_mispred};
`endif

endmodule
